// File: rtl/kim_hazard_scoreboard.sv
// Per-GPR countdown scoreboard in ID: stalls on load-use, branch-in-ID and MDU-busy hazards.
// Optional performance counters are built only when KIM_HAZARD_PERF_CNT_EN is defined.
module kim_hazard_scoreboard #(
  parameter int OPERAND_ADDR_WIDTH = 5,
  parameter int LOAD_USE_STALL     = 1,
  parameter int BRANCH_EXTRA       = 1,
  parameter int MDU_LATENCY        = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              hold,
  input  logic                              id_valid,
  input  logic [OPERAND_ADDR_WIDTH-1:0]     id_rs,
  input  logic [OPERAND_ADDR_WIDTH-1:0]     id_rt,
  input  logic                              id_uses_rs,
  input  logic                              id_uses_rt,
  input  logic                              id_is_branch,
  input  logic                              id_we,
  input  logic [OPERAND_ADDR_WIDTH-1:0]     id_dst,
  input  logic                              id_is_load,
  input  logic                              id_is_mdu,
  output logic                              stall,
  output logic                              stall_rs,
  output logic                              stall_rt,
  output logic                              stall_mdu,
  output logic [2**OPERAND_ADDR_WIDTH-1:0]  pending,
  output logic [31:0]                       perf_stall_cycles,
  output logic [31:0]                       perf_load_use
);

  localparam int NUM_REGS  = 2**OPERAND_ADDR_WIDTH;
  localparam int CNT_WIDTH = $clog2(MDU_LATENCY + LOAD_USE_STALL + BRANCH_EXTRA + 1);

  localparam logic [CNT_WIDTH-1:0] LOAD_VAL   = CNT_WIDTH'(LOAD_USE_STALL + BRANCH_EXTRA);
  localparam logic [CNT_WIDTH-1:0] MDU_VAL    = CNT_WIDTH'(MDU_LATENCY + BRANCH_EXTRA);
  localparam logic [CNT_WIDTH-1:0] ALU_VAL    = CNT_WIDTH'(BRANCH_EXTRA);
  localparam logic [CNT_WIDTH-1:0] MDU_BUSY   = CNT_WIDTH'(MDU_LATENCY);

  logic [CNT_WIDTH-1:0] cnt_reg [NUM_REGS];
  logic [CNT_WIDTH-1:0] mdu_cnt_reg;

  logic [CNT_WIDTH-1:0] threshold;
  logic                 hz_rs;
  logic                 hz_rt;
  logic                 hz_mdu;
  logic                 issue;
  logic                 load_dst;
  logic [CNT_WIDTH-1:0] load_val;

  // A branch reads its operands in ID, so it needs the producer fully drained;
  // EX consumers can tolerate BRANCH_EXTRA remaining cycles thanks to forwarding.
  assign threshold = id_is_branch ? '0 : ALU_VAL;

  assign hz_rs  = id_valid & id_uses_rs & (id_rs != '0) & (cnt_reg[id_rs] > threshold);
  assign hz_rt  = id_valid & id_uses_rt & (id_rt != '0) & (cnt_reg[id_rt] > threshold);
  assign hz_mdu = id_valid & id_is_mdu & (mdu_cnt_reg != '0);

  assign stall     = hz_rs | hz_rt | hz_mdu;
  assign stall_rs  = hz_rs;
  assign stall_rt  = hz_rt;
  assign stall_mdu = hz_mdu;

  assign issue    = id_valid & ~stall & ~hold;
  assign load_dst = issue & id_we & (id_dst != '0);

  always_comb begin
    load_val = ALU_VAL;
    if (id_is_load) begin
      load_val = LOAD_VAL;
    end else if (id_is_mdu) begin
      load_val = MDU_VAL;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign cnt_reg[gi] = '0;
        assign pending[gi] = 1'b0;
      end else begin : g_track
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_reg[gi] <= '0;
          end else if (!hold) begin
            // Newest writer always wins, even over a longer outstanding count (WAW).
            if (load_dst && (id_dst == OPERAND_ADDR_WIDTH'(gi))) begin
              cnt_reg[gi] <= load_val;
            end else if (cnt_reg[gi] != '0) begin
              cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
            end
          end
        end
        assign pending[gi] = (cnt_reg[gi] != '0);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt_reg <= '0;
    end else if (!hold) begin
      if (issue && id_is_mdu) begin
        mdu_cnt_reg <= MDU_BUSY;
      end else if (mdu_cnt_reg != '0) begin
        mdu_cnt_reg <= mdu_cnt_reg - 1'b1;
      end
    end
  end

`ifdef KIM_HAZARD_PERF_CNT_EN
  logic [NUM_REGS-1:0] is_load_reg;
  logic                load_hz;
  logic                load_hz_prev_reg;
  logic [31:0]         perf_stall_cycles_reg;
  logic [31:0]         perf_load_use_reg;

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_tag
      if (gi == 0) begin : g_zero
        assign is_load_reg[gi] = 1'b0;
      end else begin : g_track
        always_ff @(posedge clk) begin
          if (reset) begin
            is_load_reg[gi] <= 1'b0;
          end else if (!hold && load_dst && (id_dst == OPERAND_ADDR_WIDTH'(gi))) begin
            is_load_reg[gi] <= id_is_load;
          end
        end
      end
    end
  endgenerate

  assign load_hz = (hz_rs & is_load_reg[id_rs]) | (hz_rt & is_load_reg[id_rt]);

  // A multi-cycle load-use stall is one event: count only its first unfrozen cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles_reg <= '0;
      perf_load_use_reg     <= '0;
      load_hz_prev_reg      <= 1'b0;
    end else if (!hold) begin
      load_hz_prev_reg <= load_hz;
      if (stall) begin
        perf_stall_cycles_reg <= perf_stall_cycles_reg + 32'd1;
      end
      if (load_hz && !load_hz_prev_reg) begin
        perf_load_use_reg <= perf_load_use_reg + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_reg;
  assign perf_load_use     = perf_load_use_reg;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_load_use     = 32'd0;
`endif

endmodule

// File: tb/tb_kim_hazard_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a ready-time model.
module tb_kim_hazard_scoreboard;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int LUS = 1;
  localparam int BE  = 1;
  localparam int MDL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, hold, id_valid, id_uses_rs, id_uses_rt, id_is_branch;
  logic          id_we, id_is_load, id_is_mdu;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          stall, stall_rs, stall_rt, stall_mdu;
  logic [NR-1:0] pending;
  logic [31:0]   perf_stall_cycles, perf_load_use;

  kim_hazard_scoreboard #(
    .OPERAND_ADDR_WIDTH(AW), .LOAD_USE_STALL(LUS), .BRANCH_EXTRA(BE), .MDU_LATENCY(MDL)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_we(id_we), .id_dst(id_dst),
    .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt), .stall_mdu(stall_mdu),
    .pending(pending), .perf_stall_cycles(perf_stall_cycles), .perf_load_use(perf_load_use)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each register becomes ready at an absolute tick; ticks advance only on unfrozen edges.
  longint tick;
  longint avail [NR];
  longint mdu_free;
  bit     ld_tag [NR];
  int     m_perf_sc, m_perf_lu;
  bit     m_lu_prev;

  task automatic model_reset();
    tick = 0; mdu_free = 0; m_perf_sc = 0; m_perf_lu = 0; m_lu_prev = 0;
    for (int r = 0; r < NR; r++) begin avail[r] = 0; ld_tag[r] = 0; end
  endtask

  function automatic longint remain(input int r);
    return (avail[r] > tick) ? avail[r] - tick : 0;
  endfunction

  task automatic apply(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit br, input bit we, input int dst, input bit ld, input bit mdu,
                       input bit hl, input bit rst);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_we = we; id_dst = AW'(dst); id_is_load = ld; id_is_mdu = mdu;
    hold = hl; reset = rst;
  endtask

  // Check outputs of the cycle in progress, advance the model, then cross one clock edge.
  task automatic step(output bit dut_stall);
    longint thr;
    bit ers, ert, emdu, est, lh;
    logic [31:0] pe;
    int dst;
    #1;
    thr  = id_is_branch ? 0 : BE;
    ers  = id_valid && id_uses_rs && id_rs != 0 && remain(int'(id_rs)) > thr;
    ert  = id_valid && id_uses_rt && id_rt != 0 && remain(int'(id_rt)) > thr;
    emdu = id_valid && id_is_mdu && mdu_free > tick;
    est  = ers || ert || emdu;
    pe   = '0;
    for (int r = 1; r < NR; r++) pe[r] = avail[r] > tick;
    check_eq("stall", 32'(stall), 32'(est));
    check_eq("stall_rs", 32'(stall_rs), 32'(ers));
    check_eq("stall_rt", 32'(stall_rt), 32'(ert));
    check_eq("stall_mdu", 32'(stall_mdu), 32'(emdu));
    check_eq("pending", pending, pe);
`ifdef KIM_HAZARD_PERF_CNT_EN
    check_eq("perf_stall_cycles", perf_stall_cycles, 32'(m_perf_sc));
    check_eq("perf_load_use", perf_load_use, 32'(m_perf_lu));
`else
    check_eq("perf_stall_cycles", perf_stall_cycles, 32'd0);
    check_eq("perf_load_use", perf_load_use, 32'd0);
`endif
    dut_stall = stall;
    if (reset) begin
      model_reset();
    end else if (!hold) begin
      lh = (ers && ld_tag[int'(id_rs)]) || (ert && ld_tag[int'(id_rt)]);
      if (est) m_perf_sc++;
      if (lh && !m_lu_prev) m_perf_lu++;
      m_lu_prev = lh;
      tick++;
      dst = int'(id_dst);
      if (id_valid && !est && id_we && dst != 0) begin
        avail[dst]  = tick + (id_is_load ? LUS + BE : id_is_mdu ? MDL + BE : BE);
        ld_tag[dst] = id_is_load;
      end
      if (id_valid && !est && id_is_mdu) mdu_free = tick + MDL;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(s);
    end
  endtask

  // Hold one instruction in ID until it issues; returns the number of stall cycles seen.
  task automatic run_instr(input int rs, input int rt, input bit urs, input bit urt, input bit br,
                           input bit we, input int dst, input bit ld, input bit mdu,
                           output int nstall);
    bit s;
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1, rs, rt, urs, urt, br, we, dst, ld, mdu, 0, 0);
      step(s);
      if (!s) return;
      nstall++;
    end
    check_eq("issue_timeout", 32'(nstall), 32'd0);
  endtask

  int n;
  bit s;

  initial begin
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_pending", pending, 32'd0);
    check_eq("reset_perf_sc", perf_stall_cycles, 32'd0);

    // lw $2 ; add $3,$2,$4
    run_instr(0, 0, 1, 0, 0, 1, 2, 1, 0, n);
    run_instr(2, 4, 1, 1, 0, 1, 3, 0, 0, n);
    check_eq("lw_add_stalls", 32'(n), 32'd1);
    $display("[TB] lw->add stall cycles %0d", n);
    idle(4);
    // lw $5 ; beq $5,$6
    run_instr(0, 0, 1, 0, 0, 1, 5, 1, 0, n);
    run_instr(5, 6, 1, 1, 1, 0, 0, 0, 0, n);
    check_eq("lw_beq_stalls", 32'(n), 32'd2);
    $display("[TB] lw->beq stall cycles %0d", n);
    idle(4);
    // add $5 ; beq $0,$5
    run_instr(1, 1, 1, 1, 0, 1, 5, 0, 0, n);
    run_instr(0, 5, 1, 1, 1, 0, 0, 0, 0, n);
    check_eq("alu_beq_stalls", 32'(n), 32'd1);
    $display("[TB] add->beq stall cycles %0d", n);
    idle(4);
    // lw $8 ; addi $7 with rt=$7 unused
    run_instr(0, 0, 1, 0, 0, 1, 8, 1, 0, n);
    run_instr(1, 7, 1, 0, 0, 1, 7, 0, 0, n);
    check_eq("itype_no_stall", 32'(n), 32'd0);
    idle(4);
    // write $0 then read $0 as a branch
    run_instr(1, 1, 1, 1, 0, 1, 0, 1, 0, n);
    run_instr(0, 0, 1, 1, 1, 0, 0, 0, 0, n);
    check_eq("zero_reg_stalls", 32'(n), 32'd0);
    check_eq("zero_reg_pending", 32'(pending[0]), 32'd0);
    idle(4);
    // mult $9 ; mult
    run_instr(1, 2, 1, 1, 0, 1, 9, 0, 1, n);
    run_instr(3, 4, 1, 1, 0, 0, 0, 0, 1, n);
    check_eq("mdu_busy_stalls", 32'(n), 32'd4);
    $display("[TB] mult->mult stall cycles %0d", n);
    idle(8);
    // mult $9 ; add reading $9
    run_instr(1, 2, 1, 1, 0, 1, 9, 0, 1, n);
    run_instr(9, 1, 1, 1, 0, 1, 10, 0, 0, n);
    check_eq("mdu_use_stalls", 32'(n), 32'd4);
    $display("[TB] mult->add stall cycles %0d", n);
    idle(8);
    // lw $2 ; add $3,$2 held for 3 cycles
    run_instr(0, 0, 1, 0, 0, 1, 2, 1, 0, n);
    for (int i = 0; i < 3; i++) begin
      apply(1, 2, 4, 1, 1, 0, 1, 3, 0, 0, 1, 0);
      step(s);
      check_eq("hold_stall", 32'(s), 32'd1);
    end
    run_instr(2, 4, 1, 1, 0, 1, 3, 0, 0, n);
    check_eq("after_hold_stalls", 32'(n), 32'd1);
    $display("[TB] hold release stall cycles %0d", n);
    idle(4);
    // reset while stalled
    run_instr(0, 0, 1, 0, 0, 1, 2, 1, 0, n);
    apply(1, 2, 4, 1, 1, 0, 1, 3, 0, 0, 0, 1);
    step(s);
    check_eq("pre_reset_stall", 32'(s), 32'd1);
    apply(1, 2, 4, 1, 1, 0, 1, 3, 0, 0, 0, 0);
    #1;
    check_eq("post_reset_stall", 32'(stall), 32'd0);
    check_eq("post_reset_pending", pending, 32'd0);
    step(s);
    $display("[TB] reset mid-stall cleared");
    idle(4);

    // Random traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(1), $urandom_range(4) == 0,
            $urandom_range(3) != 0, $urandom_range(7),
            $urandom_range(3) == 0, $urandom_range(6) == 0,
            $urandom_range(9) == 0, $urandom_range(199) == 0);
      if (id_is_load) id_is_mdu = 1'b0;
      step(s);
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
